// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file dump reader.
package regfile_pkg;

  localparam int NUM_REGS = 25;
  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 128;
  localparam int VEC_BIT  = 5;
  localparam int IDX_W    = 5;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    FINISH
  } dump_state_t;

endpackage

// File: rtl/dump_addr_gen.sv
// Bank/index walker for the dump reader: scalar bank first, then vector bank,
// skipping any bank not enabled in the latched mode.
module dump_addr_gen
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] addr,
  output logic              is_last
);

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_REGS - 1);

  logic             vec_bank;
  logic             vec_en;
  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_bank <= 1'b0;
      vec_en   <= 1'b0;
      idx      <= '0;
    end else if (load) begin
      vec_en   <= mode[1];
      vec_bank <= ~mode[0];
      idx      <= '0;
    end else if (advance) begin
      if (idx == IDX_MAX) begin
        // Only reachable on the scalar bank with the vector bank still to go.
        if (!vec_bank && vec_en) begin
          vec_bank <= 1'b1;
          idx      <= '0;
        end
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign addr    = {vec_bank, idx};
  assign is_last = (idx == IDX_MAX) && (vec_bank || !vec_en);

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks the register file read port and streams each register over valid/ready.
//   state  | meaning
//   IDLE   | waiting for start; done may pulse here for one cycle
//   READ   | capture rf_data/rf_addr into the output beat
//   SEND   | beat presented, wait for out_ready, then advance or finish
//   FINISH | raise done, drop busy, return to IDLE
module regfile_dump_reader
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  dump_state_t       state;
  logic              gen_load;
  logic              gen_adv;
  logic              gen_last;
  logic [ADDR_W-1:0] gen_addr;

  assign gen_load = (state == IDLE) && start && (mode != 2'b00);
  assign gen_adv  = (state == SEND) && out_valid && out_ready && !out_last;
  assign rf_addr  = gen_addr;

  dump_addr_gen u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (gen_load),
    .advance (gen_adv),
    .mode    (mode),
    .addr    (gen_addr),
    .is_last (gen_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            state <= (mode != 2'b00) ? READ : FINISH;
          end
        end
        READ: begin
          out_data  <= rf_data;
          out_addr  <= rf_addr;
          out_last  <= gen_last;
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state     <= out_last ? FINISH : READ;
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized bench for regfile_dump_reader against a queue-based model of the dump.
module tb_regfile_dump_reader;
  import regfile_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] mem [0:63];
  assign rf_data = mem[rf_addr];

  regfile_dump_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: the ordered list of addresses still owed by the current dump.
  logic [ADDR_W-1:0] exp_q [$];
  int                pops;
  int                stall_seen;
  int                first_valid_cyc;
  int                done_cyc;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] e;
  logic              prev_v, prev_hs, prev_done, prev_last;
  logic [DATA_W-1:0] prev_data;
  logic [ADDR_W-1:0] prev_addr;

  task automatic build_exp(input logic [1:0] m);
    for (int b = 0; b < 2; b++)
      if (m[b])
        for (int i = 0; i < NUM_REGS; i++) exp_q.push_back(ADDR_W'(b * 32 + i));
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_v    = 1'b0;
      prev_hs   = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (out_valid && prev_v && !prev_hs) begin
        check("hold_data", out_data, prev_data);
        check("hold_addr", out_addr, prev_addr);
        check("hold_last", out_last, prev_last);
      end
      if (out_valid && !prev_v && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && !out_ready && out_addr == 6'h03) stall_seen++;
      if (out_valid && out_ready) begin
        check("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          if (pops == 0) first_addr = out_addr;
          pops++;
          check("beat_addr", out_addr, e);
          check("beat_data", out_data, mem[e]);
          check("beat_last", out_last, exp_q.size() == 0);
        end
      end
      if (done) begin
        check("done_drained", exp_q.size() == 0, 1'b1);
        check("done_busy", busy, 1'b0);
        check("done_width", prev_done, 1'b0);
        if (done_cyc < 0) done_cyc = cyc;
      end
      prev_v    = out_valid;
      prev_hs   = out_valid && out_ready;
      prev_done = done;
      prev_data = out_data;
      prev_addr = out_addr;
      prev_last = out_last;
    end
  end

  // Consumer: 0 = always ready, 1 = random, 2 = 5-cycle stall on addr 0x03
  int ready_mode = 0;
  int stall_cnt  = 0;
  bit stall_arm  = 1'b0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
          end else if (stall_arm && out_valid && out_addr == 6'h03) begin
            out_ready = 1'b0;
            stall_cnt = 4;
            stall_arm = 1'b0;
          end else out_ready = 1'b1;
        end
      endcase
    end
  end

  task automatic do_start(input logic [1:0] m, input bit accept, output int drive_cyc);
    @(posedge clk);
    #1;
    start     = 1'b1;
    mode      = m;
    drive_cyc = cyc;
    if (accept) begin
      pops            = 0;
      first_valid_cyc = -1;
      done_cyc        = -1;
      build_exp(m);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    mode  = 2'($urandom);
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done_cyc < 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({name, "_timeout"}, done_cyc >= 0, 1'b1);
  endtask

  task automatic wait_pops(input int k, input int budget, input string name);
    int n = 0;
    while (pops < k && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({name, "_timeout"}, pops >= k, 1'b1);
  endtask

  task automatic preload();
    for (int i = 0; i < 64; i++) mem[i] = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      mem[i]      = DATA_W'(i);
      mem[32 + i] = {4{32'hA0 + 32'(i)}};
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rf_addr"}, rf_addr, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_addr"}, out_addr, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    int d;
    int nb;
    logic [1:0] m;
    rst   = 1'b1;
    start = 1'b0;
    mode  = 2'b00;
    pops = 0; stall_seen = 0; first_valid_cyc = -1; done_cyc = -1;
    preload();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Pin the model against hand-derived addresses for a full dump.
    build_exp(2'b11);
    check("model_len", exp_q.size(), 50);
    check("model_vec0", exp_q[25], 6'h20);
    check("model_lastaddr", exp_q[49], 6'h38);
    exp_q.delete();

    // Full dump, consumer always ready
    ready_mode = 0;
    do_start(2'b11, 1'b1, d);
    wait_done(300, "full");
    check("full_beats", pops, 50);
    check("full_first_valid_lat", first_valid_cyc - d, 2);
    check("full_done_lat", done_cyc - d, 102);

    // Vector bank only
    do_start(2'b10, 1'b1, d);
    wait_done(200, "vec");
    check("vec_beats", pops, 25);
    check("vec_first_addr", first_addr, 6'h20);

    // Empty mode: no beats, busy for one cycle, done two cycles after start
    do_start(2'b00, 1'b1, d);
    check("m0_busy_on", busy, 1'b1);
    @(posedge clk);
    #1;
    check("m0_busy_off", busy, 1'b0);
    check("m0_done", done, 1'b1);
    wait_done(10, "m0");
    check("m0_done_lat", done_cyc - d, 2);
    check("m0_beats", pops, 0);

    // Backpressure on addr 0x03
    ready_mode = 2;
    stall_arm  = 1'b1;
    stall_seen = 0;
    do_start(2'b01, 1'b1, d);
    wait_done(200, "stall");
    check("stall_cycles", stall_seen, 5);
    check("stall_beats", pops, 25);

    // Reset mid-dump, then a clean restart from 0x00
    ready_mode = 1;
    do_start(2'b11, 1'b1, d);
    wait_pops(10, 400, "rst_wait");
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check_all_zero("abort");
    rst = 1'b0;
    ready_mode = 0;
    do_start(2'b11, 1'b1, d);
    wait_done(300, "restart");
    check("restart_first_addr", first_addr, 6'h00);
    check("restart_beats", pops, 50);

    // start while busy is ignored
    ready_mode = 1;
    do_start(2'b11, 1'b1, d);
    wait_pops(5, 400, "busy_wait");
    do_start(2'b01, 1'b0, nb);
    wait_done(600, "busy_start");
    check("busy_start_beats", pops, 50);
    repeat (10) @(posedge clk);

    // Random contents, modes and backpressure
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
      m = 2'($urandom_range(0, 3));
      do_start(m, 1'b1, d);
      wait_done(700, "rand");
      check("rand_beats", pops, 25 * (int'(m[0]) + int'(m[1])));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
